// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller.
// Merges per-stage stall requests into a per-stage hold vector, issues a flush
// on branch mispredict (deferring it while EX/MEM hold the pipe), counts
// stalled cycles and freezes the pipe if a stall persists too long.
//
// Ports:
//   clk          - clock, all state updates on rising edge
//   rst          - synchronous active-high reset
//   stallreq_id  - ID load-use hazard stall request
//   stallreq_ex  - EX multi-cycle busy stall request
//   stallreq_mem - MEM data wait stall request
//   mispredict   - single-cycle branch mispredict pulse from EX
//   stall[5:0]   - per-stage hold: [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=WB
//   flush        - squash IF/ID and ID/EX this cycle
//   timeout      - stall watchdog fired, pipeline frozen until reset
//   stall_cycles - saturating count of cycles with stall != 0
//   state        - FSM state (0=RUN 1=STALL 2=PEND 3=FAULT)
module pipeline_ctrl #(
  parameter int unsigned WDOG_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        mispredict,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        timeout,
  output logic [31:0] stall_cycles,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StPend  = 2'd2,
    StFault = 2'd3
  } state_e;

  localparam logic [31:0] CntMax = 32'hFFFF_FFFF;

  state_e      state_q, state_d;
  logic [31:0] consec_q, consec_d;
  logic [31:0] cycles_q, cycles_d;
  logic        hold;
  logic [5:0]  stall_req;
  logic        stall_nz;
  logic        fault_hit;

  // Stall vector, flush and counter next-state
  always_comb begin
    hold      = stallreq_ex | stallreq_mem;
    stall_req = 6'b000000;
    if (stallreq_mem) begin
      stall_req = 6'b011111;
    end else if (stallreq_ex) begin
      stall_req = 6'b001111;
    end else if (stallreq_id) begin
      stall_req = 6'b000111;
    end

    // A deferred (PEND) flush fires on the first cycle EX/MEM stop holding.
    flush = ~rst & (mispredict | (state_q == StPend)) & ~hold & (state_q != StFault);

    stall = stall_req;
    if (rst) begin
      stall = 6'b000000;
    end else if (state_q == StFault) begin
      stall = 6'b111111;
    end else if (flush) begin
      // The load-use instruction requesting the ID stall is being squashed.
      stall = 6'b000000;
    end

    stall_nz = |stall;

    consec_d = 32'd0;
    cycles_d = cycles_q;
    if (stall_nz) begin
      consec_d = (consec_q == CntMax) ? consec_q : consec_q + 32'd1;
      cycles_d = (cycles_q == CntMax) ? cycles_q : cycles_q + 32'd1;
    end

    fault_hit = stall_nz & (consec_d >= WDOG_LIMIT);
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    if (state_q == StFault) begin
      state_d = StFault;
    end else if (fault_hit) begin
      state_d = StFault;
    end else begin
      unique case (state_q)
        StPend: begin
          // Further mispredicts while pending merge into the single deferred flush.
          if (flush) begin
            state_d = StRun;
          end
        end
        StRun, StStall: begin
          if (mispredict & hold) begin
            state_d = StPend;
          end else if (stall_nz) begin
            state_d = StStall;
          end else begin
            state_d = StRun;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      consec_q <= 32'd0;
      cycles_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      consec_q <= consec_d;
      cycles_q <= cycles_d;
    end
  end

  assign timeout      = (state_q == StFault);
  assign stall_cycles = cycles_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        mispredict;
  logic [5:0]  stall;
  logic        flush;
  logic        timeout;
  logic [31:0] stall_cycles;
  logic [1:0]  state;

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] PEND  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [1:0]  state;
    logic [31:0] cyc;
    logic        timeout;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pipeline_ctrl #(.WDOG_LIMIT(255)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .mispredict   (mispredict),
    .stall        (stall),
    .flush        (flush),
    .timeout      (timeout),
    .stall_cycles (stall_cycles),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock of stimulus: drive, push expectation, check comb outputs before
  // the edge and registered outputs after it.
  task automatic step(input string tag, input logic r, input logic id, input logic ex,
                      input logic mem, input logic mp, input logic [5:0] e_stall,
                      input logic e_flush, input logic [1:0] e_state,
                      input logic [31:0] e_cyc, input logic e_to);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst          = r;
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    mispredict   = mp;
    e.stall   = e_stall;
    e.flush   = e_flush;
    e.state   = e_state;
    e.cyc     = e_cyc;
    e.timeout = e_to;
    exp_q.push_back(e);
    #2;
    got = exp_q.pop_front();
    check({tag, ".stall"}, 32'(stall), 32'(got.stall));
    check({tag, ".flush"}, 32'(flush), 32'(got.flush));
    @(posedge clk);
    #1;
    check({tag, ".state"}, 32'(state), 32'(got.state));
    check({tag, ".stall_cycles"}, stall_cycles, got.cyc);
    check({tag, ".timeout"}, 32'(timeout), 32'(got.timeout));
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
    mispredict = 1'b0;

    // Reset dominates all inputs
    step("rst0", 1, 1, 1, 1, 1, 6'b000000, 0, RUN, 0, 0);
    step("rst1", 1, 1, 0, 0, 1, 6'b000000, 0, RUN, 0, 0);

    // Single ID stall
    step("id1",  0, 1, 0, 0, 0, 6'b000111, 0, STALL, 1, 0);
    step("id2",  0, 0, 0, 0, 0, 6'b000000, 0, RUN,   1, 0);

    // Priority mem > id, then mem drops
    step("pri1", 0, 1, 0, 1, 0, 6'b011111, 0, STALL, 2, 0);
    step("pri2", 0, 1, 0, 0, 0, 6'b000111, 0, STALL, 3, 0);
    step("pri3", 0, 0, 0, 0, 0, 6'b000000, 0, RUN,   3, 0);

    // Mispredict deferred under MEM hold for 3 cycles
    step("pend1", 0, 0, 0, 1, 1, 6'b011111, 0, PEND, 4, 0);
    step("pend2", 0, 0, 0, 1, 0, 6'b011111, 0, PEND, 5, 0);
    step("pend3", 0, 0, 0, 1, 0, 6'b011111, 0, PEND, 6, 0);
    step("pend4", 0, 0, 0, 0, 0, 6'b000000, 1, RUN,  6, 0);
    step("pend5", 0, 0, 0, 0, 0, 6'b000000, 0, RUN,  6, 0);

    // Mispredict with ID stall and no hold: flush overrides stall
    step("mpid1", 0, 1, 0, 0, 1, 6'b000000, 1, RUN, 6, 0);
    step("mpid2", 0, 0, 0, 0, 0, 6'b000000, 0, RUN, 6, 0);

    // Repeated mispredicts in PEND merge into one flush
    step("merge1", 0, 0, 1, 0, 1, 6'b001111, 0, PEND, 7, 0);
    step("merge2", 0, 0, 1, 0, 1, 6'b001111, 0, PEND, 8, 0);
    step("merge3", 0, 0, 0, 0, 1, 6'b000000, 1, RUN,  8, 0);
    step("merge4", 0, 0, 0, 0, 0, 6'b000000, 0, RUN,  8, 0);

    // Reset while PEND discards the deferred flush
    step("rpend1", 0, 0, 0, 1, 1, 6'b011111, 0, PEND, 9, 0);
    step("rpend2", 1, 0, 0, 0, 0, 6'b000000, 0, RUN,  0, 0);
    step("rpend3", 0, 0, 0, 0, 0, 6'b000000, 0, RUN,  0, 0);

    // Watchdog: 255 consecutive EX stall cycles
    for (int i = 0; i < 255; i++) begin
      step("wdog", 0, 0, 1, 0, 0, 6'b001111, 0, (i == 254) ? FAULT : STALL,
           32'(i + 1), (i == 254));
    end
    step("fault1", 0, 0, 0, 0, 1, 6'b111111, 0, FAULT, 256, 1);
    step("fault2", 0, 1, 0, 0, 0, 6'b111111, 0, FAULT, 257, 1);
    step("frst1",  1, 0, 0, 0, 0, 6'b000000, 0, RUN,   0,   0);
    step("frst2",  0, 0, 0, 0, 0, 6'b000000, 0, RUN,   0,   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
